alu_console: RTL and testbench
==============================

// Module: alu_console
// PURPOSE
//  Parametrised touchscreen front-end for a multi-cycle ALU. Touchscreen entries load the control
//  word and both operands. A GO entry launches the ALU through a start/done handshake with timeout.
//  Each completed op is pushed into a result history ring; all state is muxed onto the LCD display slots.
//  Sits between lcd_module and alu; drives alu inputs, samples alu outputs.
// PARAMETERS
//  DATA_W      32   operand/result width, 1..32; zero-extended to 32 on display
//  CTRL_W      14   ALU control word width, 1..32
//  HIST_DEPTH  8    history ring entries, 1..38 (slots 7..6+HIST_DEPTH)
//  TIMEOUT     1024 max cycles in WAIT before abort, >=2
//  AUTO_GO     0    1: any accepted operand/control write also launches an op
// PORTS
//  clk             in   1        system clock
//  resetn          in   1        asynchronous active-low reset
//  input_sel       in   2        00 GO, 01 control, 10 src1, 11 src2
//  input_valid     in   1        1-cycle strobe from lcd_module
//  input_value     in   32       touchscreen value
//  display_number  in   6        slot requested by lcd_module, 1..44
//  display_valid   out  1        slot has content
//  display_name    out  40       5 ASCII chars
//  display_value   out  32       slot value
//  alu_control     out  CTRL_W   registered control word
//  alu_src1        out  DATA_W   registered operand 1
//  alu_src2        out  DATA_W   registered operand 2
//  alu_start       out  1        1-cycle launch pulse
//  alu_done        in   1        result valid, sampled only in WAIT
//  alu_result      in   DATA_W   ALU result
//  alu_odd         in   DATA_W   divider remainder
//  busy            out  1        FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs, operands, control, history, counters 0; FSM IDLE.
//  Writes: on input_valid with FSM IDLE, sel 01/10/11 loads input_value[CTRL_W-1:0]/[DATA_W-1:0].
//  Write while busy: dropped; reject_cnt++ (8b, saturates at 255).
//  FSM IDLE->ISSUE: on GO strobe, or on accepted write when AUTO_GO=1.
//  FSM ISSUE->WAIT: unconditional. alu_start=1 exactly in ISSUE (one cycle, cycle after strobe).
//  FSM WAIT->IDLE on alu_done: latch res/odd, push ring, clear tmo_err.
//  FSM WAIT->IDLE on timeout: TIMEOUT cycles in WAIT without done; res=odd=0, tmo_err=1, no push.
//  Done and timeout in the same cycle: done wins.
//  alu_done outside WAIT: ignored. GO while busy: counts as reject.
//  Ring: wr_ptr wraps HIST_DEPTH-1 -> 0; when full, the oldest entry is overwritten.
//  Ring: hist_cnt saturates at HIST_DEPTH.
//  Display: registered, value appears 1 cycle after display_number.
//  Slot 1 SRC_1, 2 SRC_2, 3 CONTR, 4 RESUL, 5 ODD.
//  Slot 6 STATE = {reject_cnt[7:0], hist_cnt[7:0], 13'd0, tmo_err, state[1:0]}.
//  State code: IDLE 0, ISSUE 1, WAIT 2.
//  Slot 7+k, "HISdd" (dd = k as two ASCII decimal digits): k-th newest result, k=0 newest.
//  Slot 7+k valid only if k<hist_cnt; else display_valid=0, name/value 0.
//  Any other slot: display_valid=0, name=0, value=0.
//  Reset mid-op: FSM to IDLE immediately; alu_start deasserts asynchronously.
// TESTING
//  1 Idle writes: src1=7, src2=3, ctrl=0x0004 -> slots 1/2/3 read 7/3/0x4; no alu_start.
//  2 GO -> alu_start pulses 1 cycle. Done at WAIT cycle 3, result=10 -> slot4=10, slot7 "HIS00"=10, busy low.
//  3 HIST_DEPTH=8, 10 ops with results 1..10 -> HIS00=10, HIS07=3.
//  3 (cont.) Slot 15 display_valid=0; hist_cnt field=8.
//  4 Write src1 while WAIT -> src1 unchanged, reject_cnt=1.
//  4 (cont.) Done coincident with timeout -> result captured, tmo_err=0.
//  5 No done for TIMEOUT cycles -> slot4=0, tmo_err=1, hist_cnt unchanged, busy low.
//  6 AUTO_GO=1: write src2=5 -> alu_start next cycle. resetn low in WAIT -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/alu_console.sv
// alu_console: touchscreen front-end for a multi-cycle ALU.
//   Touch entries (input_sel/input_valid/input_value) load the control word
//   and operands while idle; GO (or any accepted write when AUTO_GO=1)
//   launches the ALU with a one-cycle alu_start and waits for alu_done or a
//   timeout. Completed results are pushed into a history ring. All state is
//   muxed onto registered LCD slots (display_number -> display_valid/name/value).
// Ports:
//   clk, resetn                      clock, async active-low reset
//   input_sel/valid/value            touchscreen write strobe (00 GO,01 ctrl,10 src1,11 src2)
//   display_number -> display_*      slot request / registered slot contents
//   alu_control/src1/src2/start      ALU drive side
//   alu_done/result/odd              ALU return side (sampled only in WAIT)
//   busy                             FSM not IDLE
module alu_console #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 14,
  parameter int HIST_DEPTH = 8,
  parameter int TIMEOUT    = 1024,
  parameter int AUTO_GO    = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        input_sel,
  input  logic              input_valid,
  input  logic [31:0]       input_value,
  input  logic [5:0]        display_number,
  output logic              display_valid,
  output logic [39:0]       display_name,
  output logic [31:0]       display_value,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_odd,
  output logic              busy
);

  localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int CW = $clog2(HIST_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [DATA_W-1:0] res_q, res_d, odd_q, odd_d;
  logic              tmo_err_q, tmo_err_d;
  logic [7:0]        rej_q, rej_d;
  logic [CW-1:0]     hcnt_q, hcnt_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              push;
  logic [DATA_W-1:0] hist_q [HIST_DEPTH];

  logic              dv_q, dv_d;
  logic [39:0]       dn_q, dn_d;
  logic [31:0]       dval_q, dval_d;

  // Upper input_value bits are ignored when CTRL_W/DATA_W < 32.
  logic unused_in;
  assign unused_in = ^input_value;

  // Control FSM and datapath next-state.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    res_d     = res_q;
    odd_d     = odd_q;
    tmo_err_d = tmo_err_q;
    rej_d     = rej_q;
    hcnt_d    = hcnt_q;
    wptr_d    = wptr_q;
    tcnt_d    = tcnt_q;
    push      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (input_valid) begin
          case (input_sel)
            2'b01:   ctrl_d = input_value[CTRL_W-1:0];
            2'b10:   src1_d = input_value[DATA_W-1:0];
            2'b11:   src2_d = input_value[DATA_W-1:0];
            default: ;
          endcase
          if (input_sel == 2'b00 || AUTO_GO != 0) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing on the same cycle
        if (alu_done) begin
          res_d     = alu_result;
          odd_d     = alu_odd;
          tmo_err_d = 1'b0;
          push      = 1'b1;
          state_d   = S_IDLE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          res_d     = '0;
          odd_d     = '0;
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any strobe while busy (including GO) is dropped and counted.
    if (input_valid && state_q != S_IDLE && rej_q != 8'hFF) rej_d = rej_q + 8'd1;

    if (push) begin
      wptr_d = (wptr_q == PW'(HIST_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (hcnt_q != CW'(HIST_DEPTH)) hcnt_d = hcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      res_q     <= '0;
      odd_q     <= '0;
      tmo_err_q <= 1'b0;
      rej_q     <= '0;
      hcnt_q    <= '0;
      wptr_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      res_q     <= res_d;
      odd_q     <= odd_d;
      tmo_err_q <= tmo_err_d;
      rej_q     <= rej_d;
      hcnt_q    <= hcnt_d;
      wptr_q    <= wptr_d;
      tcnt_q    <= tcnt_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else if (push) begin
      hist_q[wptr_q] <= alu_result;
    end
  end

  // Display mux; k-th newest entry lives at wptr-1-k modulo depth.
  always_comb begin
    int k;
    int idx;
    dv_d   = 1'b0;
    dn_d   = '0;
    dval_d = '0;
    k      = 0;
    idx    = 0;
    case (display_number)
      6'd1: begin dv_d = 1'b1; dn_d = "SRC_1"; dval_d = 32'(src1_q); end
      6'd2: begin dv_d = 1'b1; dn_d = "SRC_2"; dval_d = 32'(src2_q); end
      6'd3: begin dv_d = 1'b1; dn_d = "CONTR"; dval_d = 32'(ctrl_q); end
      6'd4: begin dv_d = 1'b1; dn_d = "RESUL"; dval_d = 32'(res_q);  end
      6'd5: begin dv_d = 1'b1; dn_d = "ODD  "; dval_d = 32'(odd_q);  end
      6'd6: begin
        dv_d   = 1'b1;
        dn_d   = "STATE";
        dval_d = {rej_q, 8'(hcnt_q), 13'd0, tmo_err_q, state_q};
      end
      default: begin
        if (display_number >= 6'd7) begin
          k = int'(display_number) - 7;
          if (k < HIST_DEPTH && k < int'(hcnt_q)) begin
            idx = int'(wptr_q) - 1 - k;
            if (idx < 0) idx = idx + HIST_DEPTH;
            dv_d   = 1'b1;
            dn_d   = {"HIS", 8'h30 + 8'(k / 10), 8'h30 + 8'(k % 10)};
            dval_d = 32'(hist_q[PW'(idx)]);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dv_q   <= 1'b0;
      dn_q   <= '0;
      dval_q <= '0;
    end else begin
      dv_q   <= dv_d;
      dn_q   <= dn_d;
      dval_q <= dval_d;
    end
  end

  assign display_valid = dv_q;
  assign display_name  = dn_q;
  assign display_value = dval_q;
  assign alu_control   = ctrl_q;
  assign alu_src1      = src1_q;
  assign alu_src2      = src2_q;
  assign alu_start     = (state_q == S_ISSUE);
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_console.sv
module tb_alu_console;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  sel;
  logic        valid;
  logic [31:0] val;
  logic [5:0]  num;
  logic        dv;
  logic [39:0] dn;
  logic [31:0] dval;
  logic [13:0] ctl;
  logic [31:0] s1, s2;
  logic        start;
  logic        done;
  logic [31:0] res, odd;
  logic        busy;

  logic [1:0]  sel2;
  logic        valid2;
  logic [31:0] val2;
  logic [5:0]  num2;
  logic        dv2;
  logic [39:0] dn2;
  logic [31:0] dval2;
  logic [13:0] ctl2;
  logic [31:0] s1_2, s2_2;
  logic        start2;
  logic        busy2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_console #(.TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .input_sel(sel), .input_valid(valid),
    .input_value(val), .display_number(num), .display_valid(dv),
    .display_name(dn), .display_value(dval), .alu_control(ctl),
    .alu_src1(s1), .alu_src2(s2), .alu_start(start), .alu_done(done),
    .alu_result(res), .alu_odd(odd), .busy(busy)
  );

  alu_console #(.TIMEOUT(TMO), .AUTO_GO(1)) dut2 (
    .clk(clk), .resetn(resetn), .input_sel(sel2), .input_valid(valid2),
    .input_value(val2), .display_number(num2), .display_valid(dv2),
    .display_name(dn2), .display_value(dval2), .alu_control(ctl2),
    .alu_src1(s1_2), .alu_src2(s2_2), .alu_start(start2), .alu_done(1'b0),
    .alu_result(32'd0), .alu_odd(32'd0), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] v);
    sel = s; val = v; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic rd(input int slot);
    num = 6'(slot);
    tick();
  endtask

  // launch, done on WAIT cycle 3
  task automatic op(input logic [31:0] r, input logic [31:0] o);
    wr(2'b00, 32'd0);
    tick();
    tick();
    tick();
    done = 1'b1; res = r; odd = o;
    tick();
    done = 1'b0;
  endtask

  function automatic logic [31:0] stw(input int rej, input int hc, input bit tmo, input int st);
    return {8'(rej), 8'(hc), 13'd0, tmo, 2'(st)};
  endfunction

  initial begin
    resetn = 1'b0; sel = 0; valid = 0; val = 0; num = 0; done = 0; res = 0; odd = 0;
    sel2 = 0; valid2 = 0; val2 = 0; num2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src1", s1, 0);
    chk("rst_dv", dv, 0);
    resetn = 1'b1;
    tick();
    rd(6);
    chk("rst_state_v", dv, 1);
    chk("rst_state_n", dn, "STATE");
    chk("rst_state", dval, stw(0, 0, 0, 0));

    // 1: idle writes, control truncated to 14 bits
    wr(2'b10, 32'd7);
    chk("w_nostart", start, 0);
    wr(2'b11, 32'd3);
    wr(2'b01, 32'hFFFF_C004);
    chk("w_nostart2", start, 0);
    chk("w_busy", busy, 0);
    chk("w_ctl", ctl, 14'h0004);
    rd(1); chk("slot1", dval, 7); chk("slot1_n", dn, "SRC_1");
    rd(2); chk("slot2", dval, 3);
    rd(3); chk("slot3", dval, 32'h4);

    // 2: GO handshake
    wr(2'b00, 32'd0);
    chk("go_start", start, 1);
    chk("go_busy", busy, 1);
    tick();
    chk("go_start_off", start, 0);
    tick();
    tick();
    done = 1'b1; res = 10; odd = 2;
    tick();
    done = 1'b0;
    chk("op_busy", busy, 0);
    rd(4); chk("slot4", dval, 10);
    rd(5); chk("slot5", dval, 2);
    rd(7); chk("his00_n", dn, "HIS00"); chk("his00", dval, 10);
    rd(8); chk("his01_inv", dv, 0);

    // done outside WAIT is ignored
    done = 1'b1; res = 77;
    tick();
    done = 1'b0;
    chk("idle_done_busy", busy, 0);
    rd(6); chk("idle_done_st", dval, stw(0, 1, 0, 0));

    // 3: ring wrap
    for (int i = 1; i <= 10; i++) op(32'(i), 32'd0);
    rd(7);  chk("w_his00", dval, 10);
    rd(8);  chk("w_his01", dval, 9);
    rd(14); chk("w_his07_n", dn, "HIS07"); chk("w_his07", dval, 3);
    rd(15); chk("s15_v", dv, 0); chk("s15_val", dval, 0); chk("s15_n", dn, 0);
    rd(44); chk("s44_v", dv, 0);
    rd(0);  chk("s0_v", dv, 0);
    rd(6);  chk("w_state", dval, stw(0, 8, 0, 0));

    // 5: timeout
    wr(2'b00, 32'd0);
    tick();
    repeat (TMO - 1) tick();
    chk("tmo_edge_busy", busy, 1);
    tick();
    chk("tmo_busy", busy, 0);
    rd(4); chk("tmo_res", dval, 0);
    rd(5); chk("tmo_odd", dval, 0);
    rd(6); chk("tmo_state", dval, stw(0, 8, 1, 0));
    rd(7); chk("tmo_his00", dval, 10);

    // 4: rejects while busy, done coincident with timeout
    wr(2'b00, 32'd0);
    tick();
    wr(2'b10, 32'd99);
    wr(2'b00, 32'd0);
    chk("rej_src1", s1, 7);
    repeat (TMO - 3) tick();
    chk("co_busy", busy, 1);
    done = 1'b1; res = 32'h55; odd = 0;
    tick();
    done = 1'b0;
    chk("co_idle", busy, 0);
    rd(4); chk("co_res", dval, 32'h55);
    rd(6); chk("co_state", dval, stw(2, 8, 0, 0));
    rd(7); chk("co_his00", dval, 32'h55);
    rd(8); chk("co_his01", dval, 10);

    // 6: AUTO_GO launch, async reset mid-op
    sel2 = 2'b11; val2 = 5; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    chk("ag_start", start2, 1);
    chk("ag_src2", s2_2, 5);
    tick();
    chk("ag_start_off", start2, 0);
    chk("ag_busy", busy2, 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_start", start2, 0);
    chk("ar_busy", busy2, 0);
    chk("ar_src2", s2_2, 0);
    chk("ar_dut1_src1", s1, 0);
    chk("ar_dut1_ctl", ctl, 0);
    chk("ar_dv", dv, 0);
    resetn = 1'b1;
    num2 = 6'd6;
    tick();
    chk("ar_st_v", dv2, 1);
    chk("ar_state", dval2, stw(0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
